// File: rtl/image_block_dma_master.sv
// image_block_dma_master
// Avalon-MM master that copies a block of LEN words from SRC to DST in a
// single-port image memory. An optional per-byte pixel operation is applied
// on the way through. Reads are batched into a small FIFO, and the FIFO is
// drained with writes only after every read in flight has returned. Because
// of this, reads and writes never overlap on the port.
module image_block_dma_master #(
  parameter int ADDR_W          = 17,
  parameter int DATA_W          = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W-1:0]   len,
  input  logic [1:0]          op_mode,
  input  logic [7:0]          thresh,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LANES = DATA_W / 8;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [1:0]        op_reg;
  logic [7:0]        thresh_reg;
  logic [ADDR_W-1:0] rd_issued_reg;
  logic [ADDR_W-1:0] wr_left_reg;
  logic [CNT_W-1:0]  outstanding_reg;
  logic [CNT_W-1:0]  fifo_count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic              rd_acc;
  logic              wr_acc;
  logic              beat;
  logic              can_issue;
  logic [ADDR_W-1:0] rd_issued_next;
  logic [ADDR_W-1:0] wr_left_next;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  fifo_count_next;
  logic [CNT_W:0]    reserved_next;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [DATA_W-1:0] head_next;
  logic [DATA_W-1:0] pix_next;

  assign avm_byteenable = '1;

  // Post-handshake counter values and the read-issue decision for the next cycle.
  always_comb begin
    rd_acc           = avm_read & ~avm_waitrequest;
    wr_acc           = avm_write & ~avm_waitrequest;
    beat             = avm_readdatavalid & (state_reg != S_IDLE);
    rd_issued_next   = rd_issued_reg + ADDR_W'(rd_acc);
    wr_left_next     = wr_left_reg - ADDR_W'(wr_acc);
    outstanding_next = outstanding_reg + CNT_W'(rd_acc) - CNT_W'(beat);
    fifo_count_next  = fifo_count_reg + CNT_W'(beat) - CNT_W'(wr_acc);
    wr_ptr_next      = wr_ptr_reg + PTR_W'(beat);
    rd_ptr_next      = rd_ptr_reg + PTR_W'(wr_acc);
    reserved_next    = {1'b0, fifo_count_next} + {1'b0, outstanding_next};
    // A FIFO slot is reserved for every read in flight, so returns can never overflow.
    can_issue        = (rd_issued_next != len_reg) &&
                       (outstanding_next < MAX_OUT_C) &&
                       (reserved_next < DEPTH_C);
    // When the FIFO is empty, the only possible next head is the beat arriving now.
    head_next        = (fifo_count_reg == '0) ? avm_readdata : fifo_mem[rd_ptr_next];
  end

  // Pixel function per byte lane. Opcode 3 is reserved and behaves like copy.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_in;
    assign lane_in = head_next[gi*8 +: 8];
    assign pix_next[gi*8 +: 8] =
        (op_reg == 2'd1) ? ~lane_in :
        (op_reg == 2'd2) ? ((lane_in >= thresh_reg) ? 8'hFF : 8'h00) :
                           lane_in;
  end

  // Batch buffer storage; returned read beats are appended at the write pointer.
  always_ff @(posedge clk) begin
    if (beat && !reset) begin
      fifo_mem[wr_ptr_reg] <= avm_readdata;
    end
  end

  // Control FSM, transfer counters and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      avm_read        <= 1'b0;
      avm_write       <= 1'b0;
      avm_address     <= '0;
      avm_writedata   <= '0;
      src_reg         <= '0;
      dst_reg         <= '0;
      len_reg         <= '0;
      op_reg          <= '0;
      thresh_reg      <= '0;
      rd_issued_reg   <= '0;
      wr_left_reg     <= '0;
      outstanding_reg <= '0;
      fifo_count_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      if (state_reg != S_IDLE) begin
        rd_issued_reg   <= rd_issued_next;
        wr_left_reg     <= wr_left_next;
        outstanding_reg <= outstanding_next;
        fifo_count_reg  <= fifo_count_next;
        wr_ptr_reg      <= wr_ptr_next;
        rd_ptr_reg      <= rd_ptr_next;
      end
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            src_reg         <= src_addr;
            dst_reg         <= dst_addr;
            len_reg         <= len;
            op_reg          <= op_mode;
            thresh_reg      <= thresh;
            rd_issued_reg   <= '0;
            wr_left_reg     <= len;
            outstanding_reg <= '0;
            fifo_count_reg  <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            busy            <= 1'b1;
            if (len == '0) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
            end else begin
              state_reg   <= S_READ;
              avm_read    <= 1'b1;
              avm_address <= src_addr;
            end
          end
        end
        S_READ: begin
          if (avm_read && avm_waitrequest) begin
            // Stalled request: hold the read and its address unchanged.
          end else if (can_issue) begin
            avm_read    <= 1'b1;
            avm_address <= src_reg + rd_issued_next;
          end else begin
            avm_read <= 1'b0;
            if (outstanding_next == '0) begin
              state_reg     <= S_DRAIN;
              avm_write     <= (fifo_count_next != '0);
              avm_address   <= dst_reg + (len_reg - wr_left_next);
              avm_writedata <= pix_next;
            end
          end
        end
        S_DRAIN: begin
          if (avm_write && avm_waitrequest) begin
            // Stalled write: hold address and data unchanged.
          end else if (fifo_count_next != '0) begin
            avm_write     <= 1'b1;
            avm_address   <= dst_reg + (len_reg - wr_left_next);
            avm_writedata <= pix_next;
          end else begin
            avm_write <= 1'b0;
            if (wr_left_next != '0) begin
              state_reg   <= S_READ;
              avm_read    <= can_issue;
              avm_address <= src_reg + rd_issued_next;
            end else begin
              state_reg <= S_DONE;
              done      <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_block_dma_master.sv
// Bench for image_block_dma_master. It contains a memory slave model with
// optional random waitrequest and variable read latency. Expected reads and
// writes are queued when a block is started. A monitor pops the queues and
// compares them against each transfer the slave accepts.
module tb_image_block_dma_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [16:0] src_addr = '0;
  logic [16:0] dst_addr = '0;
  logic [16:0] len = '0;
  logic [1:0]  op_mode = '0;
  logic [7:0]  thresh = '0;
  logic        busy;
  logic        done;
  logic [16:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  image_block_dma_master dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .len               (len),
    .op_mode           (op_mode),
    .thresh            (thresh),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_byteenable    (avm_byteenable),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } beat_t;

  logic [31:0] mem [0:131071];
  beat_t       rd_pend [$];
  logic [16:0] exp_rd [$];
  logic [48:0] exp_wr [$];
  logic [16:0] obs_rd [$];
  logic [48:0] obs_wr [$];

  int checks = 0;
  int errors = 0;
  int viol = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int flush_cnt = 0;
  bit rand_mode = 1'b0;

  // Slave model: everything is decided on the falling edge and takes effect at the next rising edge.
  initial begin
    int          cyc;
    int          flush_seen;
    int          last_due;
    int          model_out;
    int          model_fifo;
    int          due;
    bit          w;
    bit          prev_stall;
    logic        prev_rd;
    logic        prev_wr;
    logic [16:0] prev_addr;
    logic [31:0] prev_wd;
    beat_t       b;
    cyc = 0; flush_seen = 0; last_due = 0; model_out = 0; model_fifo = 0;
    prev_stall = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_wd = '0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (flush_cnt != flush_seen) begin
        flush_seen = flush_cnt;
        rd_pend.delete();
        model_out = 0;
        model_fifo = 0;
        last_due = cyc;
        prev_stall = 1'b0;
      end
      if (rd_pend.size() > 0 && rd_pend[0].due <= cyc) begin
        b = rd_pend.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata = b.data;
        model_out--;
        model_fifo++;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = 32'h0BADF00D;
      end
      w = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
      avm_waitrequest = w;
      if (avm_read && avm_write) viol++;
      if (prev_stall && (avm_read !== prev_rd || avm_write !== prev_wr ||
                         avm_address !== prev_addr ||
                         (prev_wr && avm_writedata !== prev_wd))) viol++;
      if (avm_read) rd_cycles++;
      if (avm_write) wr_cycles++;
      if (avm_read && !w) begin
        due = cyc + (rand_mode ? int'($urandom_range(1, 3)) : 1);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        b.data = mem[avm_address];
        b.due = due;
        rd_pend.push_back(b);
        obs_rd.push_back(avm_address);
        model_out++;
        if (model_out > 4) viol++;
      end
      if (avm_write && !w) begin
        mem[avm_address] = avm_writedata;
        obs_wr.push_back({avm_address, avm_writedata});
        model_fifo--;
      end
      if (model_fifo > 8 || model_fifo < 0) viol++;
      prev_stall = (avm_read || avm_write) && w;
      prev_rd = avm_read;
      prev_wr = avm_write;
      prev_addr = avm_address;
      prev_wd = avm_writedata;
    end
  end

  // Monitor: compare every accepted bus transfer against the scoreboard.
  initial begin
    logic [16:0] ra;
    logic [16:0] re;
    logic [48:0] wa;
    logic [48:0] we;
    forever begin
      @(posedge clk);
      while (obs_rd.size() > 0) begin
        ra = obs_rd.pop_front();
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_addr: got %h required none (unexpected read)", ra);
        end else begin
          re = exp_rd.pop_front();
          if (ra !== re) begin
            errors++;
            $display("FAIL rd_addr: got %h required %h", ra, re);
          end else begin
            $display("ok   rd  addr=%h", ra);
          end
        end
      end
      while (obs_wr.size() > 0) begin
        wa = obs_wr.pop_front();
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr: got addr=%h data=%h required none (unexpected write)",
                   wa[48:32], wa[31:0]);
        end else begin
          we = exp_wr.pop_front();
          if (wa !== we) begin
            errors++;
            $display("FAIL wr: got addr=%h data=%h required addr=%h data=%h",
                     wa[48:32], wa[31:0], we[48:32], we[31:0]);
          end else begin
            $display("ok   wr  addr=%h data=%h", wa[48:32], wa[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic push_wr(input logic [16:0] a, input logic [31:0] d);
    exp_wr.push_back({a, d});
  endtask

  // Start one block. The caller has already queued the expected writes.
  task automatic run_block(input string name, input logic [16:0] s, input logic [16:0] d,
                           input logic [16:0] n, input logic [1:0] op, input logic [7:0] th);
    int k;
    int viol0;
    int rdc0;
    int wrc0;
    for (int j = 0; j < int'(n); j++) exp_rd.push_back(s + 17'(j));
    viol0 = viol;
    rdc0 = rd_cycles;
    wrc0 = wr_cycles;
    src_addr = s; dst_addr = d; len = n; op_mode = op; thresh = th;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = ~s; dst_addr = ~d; len = 17'h00005; op_mode = ~op; thresh = ~th;
    chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    k = 1;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_pulse"}, 32'(done), 32'd1);
    if (n == '0) chk({name, "_done_latency"}, k, 1);
    @(negedge clk);
    chk({name, "_done_single"}, 32'(done), 32'd0);
    chk({name, "_busy_after_done"}, 32'(busy), 32'd0);
    chk({name, "_writes_left"}, exp_wr.size(), 0);
    chk({name, "_reads_left"}, exp_rd.size(), 0);
    chk({name, "_protocol_viol"}, viol - viol0, 0);
    if (n == '0) begin
      chk({name, "_no_read"}, rd_cycles - rdc0, 0);
      chk({name, "_no_write"}, wr_cycles - wrc0, 0);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_address", 32'(avm_address), 32'd0);
    chk("rst_writedata", avm_writedata, 32'd0);
    chk("byteenable", 32'(avm_byteenable), 32'hF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain copy of ten words.
    for (int i = 0; i < 10; i++) begin
      mem[100 + i] = 32'(i) * 32'h01010101;
      push_wr(17'(500 + i), 32'(i) * 32'h01010101);
    end
    run_block("copy", 17'd100, 17'd500, 17'd10, 2'd0, 8'h00);

    // Invert one word.
    mem[0] = 32'h00FF7F80;
    push_wr(17'd1, 32'hFF00807F);
    run_block("invert", 17'd0, 17'd1, 17'd1, 2'd1, 8'h00);

    // Threshold at 0x80; a byte equal to the threshold maps to FF.
    mem[0] = 32'h10809FFF;
    push_wr(17'd3, 32'h00FFFFFF);
    run_block("thresh", 17'd0, 17'd3, 17'd1, 2'd2, 8'h80);

    // Zero-length block.
    run_block("len0", 17'd7, 17'd9, 17'd0, 2'd0, 8'h00);

    // 37 words under random stalls and read latency; reserved opcode 3 copies.
    rand_mode = 1'b1;
    for (int i = 0; i < 37; i++) begin
      mem[1000 + i] = 32'hA5000000 | 32'(i);
      push_wr(17'(2000 + i), 32'hA5000000 | 32'(i));
    end
    run_block("stress", 17'd1000, 17'd2000, 17'd37, 2'd3, 8'h00);
    rand_mode = 1'b0;

    // Source address wraps at the top of the address space.
    mem[17'h1FFFE] = 32'hCAFE0001;
    mem[17'h1FFFF] = 32'hCAFE0002;
    mem[17'h00000] = 32'hCAFE0003;
    mem[17'h00001] = 32'hCAFE0004;
    push_wr(17'h00200, 32'hCAFE0001);
    push_wr(17'h00201, 32'hCAFE0002);
    push_wr(17'h00202, 32'hCAFE0003);
    push_wr(17'h00203, 32'hCAFE0004);
    run_block("wrap", 17'h1FFFE, 17'h00200, 17'd4, 2'd0, 8'h00);

    // Reset while writes are draining.
    for (int i = 0; i < 20; i++) begin
      mem[3000 + i] = 32'(i);
      push_wr(17'(4000 + i), ~32'(i));
      exp_rd.push_back(17'(3000 + i));
    end
    src_addr = 17'd3000; dst_addr = 17'd4000; len = 17'd20; op_mode = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!avm_write && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_drain", 32'(avm_write), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_write", 32'(avm_write), 32'd0);
    chk("abort_read", 32'(avm_read), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    flush_cnt++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // A fresh block after the abort must not see leftover FIFO contents.
    for (int i = 0; i < 6; i++) begin
      mem[5000 + i] = 32'h0BAD0000 + 32'(i);
      push_wr(17'(6000 + i), 32'h0BAD0000 + 32'(i));
    end
    run_block("after_abort", 17'd5000, 17'd6000, 17'd6, 2'd0, 8'h00);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
